// File: rtl/axis_dispatch_module.sv
// Packet dispatcher: steers whole AXI-Stream packets to one of two
// channels by a user-sideband type field and flags beat-length mismatches.
module axis_dispatch_module #(
  parameter string       P_DISPATCH_LAYER = "MAC",
  parameter logic [15:0] P_C0_TYPE        = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] s_axis_in_data,
  input  logic [79:0] s_axis_in_user,
  input  logic [7:0]  s_axis_in_keep,
  input  logic        s_axis_in_last,
  input  logic        s_axis_in_valid,
  output logic        s_axis_in_ready,
  output logic [63:0] m_axis_c0_data,
  output logic [79:0] m_axis_c0_user,
  output logic [7:0]  m_axis_c0_keep,
  output logic        m_axis_c0_last,
  output logic        m_axis_c0_valid,
  input  logic        m_axis_c0_ready,
  output logic [63:0] m_axis_c1_data,
  output logic [79:0] m_axis_c1_user,
  output logic [7:0]  m_axis_c1_keep,
  output logic        m_axis_c1_last,
  output logic        m_axis_c1_valid,
  input  logic        m_axis_c1_ready,
  output logic        o_len_err
);

  localparam bit LP_IP = (P_DISPATCH_LAYER == "IP");

  typedef enum logic [1:0] {
    S_IDLE,
    S_C0,
    S_C1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic        r_len_err;

  logic [63:0] r_c0_data;
  logic [79:0] r_c0_user;
  logic [7:0]  r_c0_keep;
  logic        r_c0_last;
  logic        r_c0_valid;
  logic [63:0] r_c1_data;
  logic [79:0] r_c1_user;
  logic [7:0]  r_c1_keep;
  logic        r_c1_last;
  logic        r_c1_valid;

  logic [15:0] w_type;
  logic [15:0] w_len;
  logic        w_dec_c1;
  logic        w_tgt_c1;
  logic        w_ready;
  logic        w_acc;
  logic        w_first;
  logic [15:0] w_cnt;
  logic [15:0] w_pkt_len;
  logic        w_err;

  assign w_type   = LP_IP ? {8'h00, s_axis_in_user[7:0]}
                          : s_axis_in_user[15:0];
  assign w_len    = LP_IP ? s_axis_in_user[55:40]
                          : s_axis_in_user[79:64];
  assign w_dec_c1 = (w_type != P_C0_TYPE);
  assign w_acc    = s_axis_in_valid && w_ready;
  assign w_first  = (r_state == S_IDLE);

  // Count of the beat being accepted now, saturating.
  assign w_cnt     = w_first ? 16'd1
                   : (r_cnt == 16'hFFFF) ? r_cnt
                   : r_cnt + 16'd1;
  assign w_pkt_len = w_first ? w_len : r_len;
  assign w_err     = w_acc && s_axis_in_last &&
                     (w_pkt_len != 16'd0) &&
                     (w_cnt != w_pkt_len);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      if (s_axis_in_last)
        w_state_nxt = S_IDLE;
      else if (w_first)
        w_state_nxt = w_dec_c1 ? S_C1 : S_C0;
    end
  end

  always_comb begin
    w_tgt_c1 = 1'b0;
    unique case (r_state)
      S_C0:    w_tgt_c1 = 1'b0;
      S_C1:    w_tgt_c1 = 1'b1;
      default: w_tgt_c1 = w_dec_c1;
    endcase
    w_ready = !i_rst && (w_tgt_c1
            ? (!r_c1_valid || m_axis_c1_ready)
            : (!r_c0_valid || m_axis_c0_ready));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_err;
      if (w_acc) begin
        r_cnt <= w_cnt;
        if (w_first) r_len <= w_len;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c0_data  <= '0;
      r_c0_user  <= '0;
      r_c0_keep  <= '0;
      r_c0_last  <= 1'b0;
      r_c0_valid <= 1'b0;
    end else if (w_acc && !w_tgt_c1) begin
      r_c0_data  <= s_axis_in_data;
      r_c0_user  <= s_axis_in_user;
      r_c0_keep  <= s_axis_in_keep;
      r_c0_last  <= s_axis_in_last;
      r_c0_valid <= 1'b1;
    end else if (m_axis_c0_ready) begin
      r_c0_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c1_data  <= '0;
      r_c1_user  <= '0;
      r_c1_keep  <= '0;
      r_c1_last  <= 1'b0;
      r_c1_valid <= 1'b0;
    end else if (w_acc && w_tgt_c1) begin
      r_c1_data  <= s_axis_in_data;
      r_c1_user  <= s_axis_in_user;
      r_c1_keep  <= s_axis_in_keep;
      r_c1_last  <= s_axis_in_last;
      r_c1_valid <= 1'b1;
    end else if (m_axis_c1_ready) begin
      r_c1_valid <= 1'b0;
    end
  end

  assign s_axis_in_ready = w_ready;
  assign m_axis_c0_data  = r_c0_data;
  assign m_axis_c0_user  = r_c0_user;
  assign m_axis_c0_keep  = r_c0_keep;
  assign m_axis_c0_last  = r_c0_last;
  assign m_axis_c0_valid = r_c0_valid;
  assign m_axis_c1_data  = r_c1_data;
  assign m_axis_c1_user  = r_c1_user;
  assign m_axis_c1_keep  = r_c1_keep;
  assign m_axis_c1_last  = r_c1_last;
  assign m_axis_c1_valid = r_c1_valid;
  assign o_len_err       = r_len_err;

endmodule

// File: tb/tb_axis_dispatch_module.sv
// Directed bench for axis_dispatch_module: MAC and IP layer instances
// driven from a vector table plus a hand-written reset sequence.
module tb_axis_dispatch_module;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic [63:0] s_data;
  logic [79:0] s_user;
  logic [7:0]  s_keep;
  logic        s_last;
  logic        s_valid;
  logic        c0_rdy;
  logic        c1_rdy;
  logic        mac_v;
  logic        ip_v;

  assign mac_v = s_valid & ~sel;
  assign ip_v  = s_valid & sel;

  logic        a_rdy, a0v, a0l, a1v, a1l, aerr;
  logic [63:0] a0d, a1d;
  logic [79:0] a0u, a1u;
  logic [7:0]  a0k, a1k;
  logic        b_rdy, b0v, b0l, b1v, b1l, berr;
  logic [63:0] b0d, b1d;
  logic [79:0] b0u, b1u;
  logic [7:0]  b0k, b1k;

  axis_dispatch_module #(
    .P_DISPATCH_LAYER("MAC"),
    .P_C0_TYPE(16'h0800)
  ) dut_mac (
    .i_clk(clk), .i_rst(rst),
    .s_axis_in_data(s_data), .s_axis_in_user(s_user),
    .s_axis_in_keep(s_keep), .s_axis_in_last(s_last),
    .s_axis_in_valid(mac_v), .s_axis_in_ready(a_rdy),
    .m_axis_c0_data(a0d), .m_axis_c0_user(a0u),
    .m_axis_c0_keep(a0k), .m_axis_c0_last(a0l),
    .m_axis_c0_valid(a0v), .m_axis_c0_ready(c0_rdy),
    .m_axis_c1_data(a1d), .m_axis_c1_user(a1u),
    .m_axis_c1_keep(a1k), .m_axis_c1_last(a1l),
    .m_axis_c1_valid(a1v), .m_axis_c1_ready(c1_rdy),
    .o_len_err(aerr)
  );

  axis_dispatch_module #(
    .P_DISPATCH_LAYER("IP"),
    .P_C0_TYPE(16'h0011)
  ) dut_ip (
    .i_clk(clk), .i_rst(rst),
    .s_axis_in_data(s_data), .s_axis_in_user(s_user),
    .s_axis_in_keep(s_keep), .s_axis_in_last(s_last),
    .s_axis_in_valid(ip_v), .s_axis_in_ready(b_rdy),
    .m_axis_c0_data(b0d), .m_axis_c0_user(b0u),
    .m_axis_c0_keep(b0k), .m_axis_c0_last(b0l),
    .m_axis_c0_valid(b0v), .m_axis_c0_ready(c0_rdy),
    .m_axis_c1_data(b1d), .m_axis_c1_user(b1u),
    .m_axis_c1_keep(b1k), .m_axis_c1_last(b1l),
    .m_axis_c1_valid(b1v), .m_axis_c1_ready(c1_rdy),
    .o_len_err(berr)
  );

  typedef struct {
    string       nm;
    logic        sel;
    logic        v;
    logic [63:0] d;
    logic [79:0] u;
    logic        l;
    logic        r0;
    logic        r1;
    logic        erdy;
    logic        e0v;
    logic [63:0] e0d;
    logic        e0l;
    logic        e1v;
    logic [63:0] e1d;
    logic        e1l;
    logic        eerr;
  } vec_t;

  vec_t tv[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic logic [79:0] mu(input logic [15:0] t,
                                     input logic [15:0] len);
    return {len, 48'h0, t};
  endfunction

  function automatic logic [79:0] ipu(input logic [7:0]  t,
                                      input logic [15:0] len);
    return {24'h0, len, 24'h0, 8'hAB, t};
  endfunction

  function automatic logic [7:0] kf(input logic [63:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction

  task automatic add(input string nm, input logic sl, input logic v,
                     input logic [63:0] d, input logic [79:0] u,
                     input logic l, input logic r0, input logic r1,
                     input logic erdy, input logic e0v,
                     input logic [63:0] e0d, input logic e0l,
                     input logic e1v, input logic [63:0] e1d,
                     input logic e1l, input logic eerr);
    vec_t t;
    t.nm = nm; t.sel = sl; t.v = v; t.d = d; t.u = u; t.l = l;
    t.r0 = r0; t.r1 = r1; t.erdy = erdy;
    t.e0v = e0v; t.e0d = e0d; t.e0l = e0l;
    t.e1v = e1v; t.e1d = e1d; t.e1l = e1l; t.eerr = eerr;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic apply(input vec_t t);
    logic r, v0, l0, v1, l1, er;
    logic [63:0] d0, d1;
    logic [7:0]  k0, k1;
    sel = t.sel; s_valid = t.v; s_data = t.d; s_user = t.u;
    s_keep = kf(t.d); s_last = t.l; c0_rdy = t.r0; c1_rdy = t.r1;
    #1;
    r = t.sel ? b_rdy : a_rdy;
    chk({t.nm, ".rdy"}, {79'h0, r}, {79'h0, t.erdy});
    @(posedge clk);
    #1;
    v0 = t.sel ? b0v : a0v; d0 = t.sel ? b0d : a0d;
    l0 = t.sel ? b0l : a0l; k0 = t.sel ? b0k : a0k;
    v1 = t.sel ? b1v : a1v; d1 = t.sel ? b1d : a1d;
    l1 = t.sel ? b1l : a1l; k1 = t.sel ? b1k : a1k;
    er = t.sel ? berr : aerr;
    chk({t.nm, ".c0v"}, {79'h0, v0}, {79'h0, t.e0v});
    chk({t.nm, ".c1v"}, {79'h0, v1}, {79'h0, t.e1v});
    chk({t.nm, ".err"}, {79'h0, er}, {79'h0, t.eerr});
    if (t.e0v) begin
      chk({t.nm, ".c0d"}, {16'h0, d0}, {16'h0, t.e0d});
      chk({t.nm, ".c0l"}, {79'h0, l0}, {79'h0, t.e0l});
      chk({t.nm, ".c0k"}, {72'h0, k0}, {72'h0, kf(t.e0d)});
    end
    if (t.e1v) begin
      chk({t.nm, ".c1d"}, {16'h0, d1}, {16'h0, t.e1d});
      chk({t.nm, ".c1l"}, {79'h0, l1}, {79'h0, t.e1l});
      chk({t.nm, ".c1k"}, {72'h0, k1}, {72'h0, kf(t.e1d)});
    end
  endtask

  initial begin
    // name sel v data user last r0 r1 | rdy c0v c0d c0l c1v c1d c1l err
    add("m4a", 0, 1, 64'hA1, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hA1, 0, 0, 0, 0, 0);
    add("m4b", 0, 1, 64'hA2, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hA2, 0, 0, 0, 0, 0);
    add("m4c", 0, 1, 64'hA3, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hA3, 0, 0, 0, 0, 0);
    add("m4d", 0, 1, 64'hA4, mu(16'h0800, 4), 1, 1, 1, 1, 1, 64'hA4, 1, 0, 0, 0, 0);
    add("m4i", 0, 0, 64'h00, mu(16'h0800, 0), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("alt1", 0, 1, 64'hB1, mu(16'h0806, 3), 0, 1, 1, 1, 0, 0, 0, 1, 64'hB1, 0, 0);
    add("alt2", 0, 1, 64'hB2, mu(16'h0806, 3), 0, 1, 1, 1, 0, 0, 0, 1, 64'hB2, 0, 0);
    add("alt3", 0, 1, 64'hB3, mu(16'h0806, 3), 1, 1, 1, 1, 0, 0, 0, 1, 64'hB3, 1, 0);
    add("alt4", 0, 1, 64'hC1, mu(16'h0800, 2), 0, 1, 1, 1, 1, 64'hC1, 0, 0, 0, 0, 0);
    add("alt5", 0, 1, 64'hC2, mu(16'h0800, 2), 1, 1, 1, 1, 1, 64'hC2, 1, 0, 0, 0, 0);
    add("alt6", 0, 1, 64'hD1, mu(16'h0806, 1), 1, 1, 1, 1, 0, 0, 0, 1, 64'hD1, 1, 0);
    add("alti", 0, 0, 64'h00, mu(16'h0800, 0), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("st1", 0, 1, 64'hE1, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hE1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      add($sformatf("st_hold%0d", i), 0, 1, 64'hE2, mu(16'h0800, 4), 0, 0, 1,
          0, 1, 64'hE1, 0, 0, 0, 0, 0);
    add("st2", 0, 1, 64'hE2, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hE2, 0, 0, 0, 0, 0);
    add("st3", 0, 1, 64'hE3, mu(16'h0800, 4), 0, 1, 1, 1, 1, 64'hE3, 0, 0, 0, 0, 0);
    add("st4", 0, 1, 64'hE4, mu(16'h0800, 4), 1, 1, 1, 1, 1, 64'hE4, 1, 0, 0, 0, 0);
    add("sti", 0, 0, 64'h00, mu(16'h0800, 0), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("le1", 0, 1, 64'hF1, mu(16'h0806, 5), 0, 1, 1, 1, 0, 0, 0, 1, 64'hF1, 0, 0);
    add("le2", 0, 1, 64'hF2, mu(16'h0806, 5), 0, 1, 1, 1, 0, 0, 0, 1, 64'hF2, 0, 0);
    add("le3", 0, 1, 64'hF3, mu(16'h0806, 5), 1, 1, 1, 1, 0, 0, 0, 1, 64'hF3, 1, 1);
    add("lei", 0, 0, 64'h00, mu(16'h0800, 0), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add("ip1", 1, 1, 64'h61, ipu(8'h11, 2), 0, 1, 1, 1, 1, 64'h61, 0, 0, 0, 0, 0);
    add("ip2", 1, 1, 64'h62, ipu(8'h11, 2), 1, 1, 1, 1, 1, 64'h62, 1, 0, 0, 0, 0);
    add("ip3", 1, 1, 64'h71, ipu(8'h01, 3), 0, 1, 1, 1, 0, 0, 0, 1, 64'h71, 0, 0);
    add("ip4", 1, 1, 64'h72, ipu(8'h01, 3), 1, 1, 1, 1, 0, 0, 0, 1, 64'h72, 1, 1);
    add("ipi", 1, 0, 64'h00, mu(16'h0800, 0), 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_user = '0;
    s_keep = '0; s_last = 1'b0; c0_rdy = 1'b1; c1_rdy = 1'b1;
    #1;
    chk("rst.rdy", {79'h0, a_rdy}, 80'h0);
    chk("rst.c0v", {78'h0, a0v, b0v}, 80'h0);
    chk("rst.c1v", {78'h0, a1v, b1v}, 80'h0);
    chk("rst.last", {78'h0, a0l, a1l}, 80'h0);
    chk("rst.data", {16'h0, a0d | a1d}, 80'h0);
    chk("rst.user", a0u | a1u, 80'h0);
    chk("rst.keep", {72'h0, a0k | a1k}, 80'h0);
    chk("rst.err", {78'h0, aerr, berr}, 80'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[i]) apply(tv[i]);

    // Reset asserted while beat 2 of a 4-beat packet is offered.
    sel = 1'b0; c0_rdy = 1'b1; c1_rdy = 1'b1;
    s_valid = 1'b1; s_data = 64'h81; s_user = mu(16'h0800, 4);
    s_keep = kf(64'h81); s_last = 1'b0;
    @(posedge clk); #1;
    chk("rm.b1v", {79'h0, a0v}, 80'h1);
    s_data = 64'h82; s_keep = kf(64'h82);
    #1 rst = 1'b1;
    #1;
    chk("rm.c0v", {79'h0, a0v}, 80'h0);
    chk("rm.c1v", {79'h0, a1v}, 80'h0);
    chk("rm.rdy", {79'h0, a_rdy}, 80'h0);
    @(posedge clk); #1;
    chk("rm.hold_rdy", {79'h0, a_rdy}, 80'h0);
    chk("rm.hold_v", {78'h0, a0v, a1v}, 80'h0);
    rst = 1'b0;
    s_data = 64'h91; s_user = mu(16'h0806, 2); s_keep = kf(64'h91);
    #1;
    chk("rp.rdy", {79'h0, a_rdy}, 80'h1);
    @(posedge clk); #1;
    chk("rp1.c1v", {79'h0, a1v}, 80'h1);
    chk("rp1.c0v", {79'h0, a0v}, 80'h0);
    chk("rp1.c1d", {16'h0, a1d}, {16'h0, 64'h91});
    chk("rp1.c1u", a1u, mu(16'h0806, 2));
    s_data = 64'h92; s_keep = kf(64'h92); s_last = 1'b1;
    @(posedge clk); #1;
    chk("rp2.c1d", {16'h0, a1d}, {16'h0, 64'h92});
    chk("rp2.c1l", {79'h0, a1l}, 80'h1);
    chk("rp2.c0v", {79'h0, a0v}, 80'h0);
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    chk("rp3.c1v", {79'h0, a1v}, 80'h0);
    chk("rp3.err", {79'h0, aerr}, 80'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
